// File: rtl/pmp_writer_pkg.sv
// Shared constants for the PMP configuration writer: region modes, response codes,
// pmpcfg field layout and the request-handling state encoding.
package pmp_writer_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_TOR   = 2'b01;
    localparam logic [1:0] MODE_NA4   = 2'b10;
    localparam logic [1:0] MODE_NAPOT = 2'b11;

    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_LOCKED = 3'd1;
    localparam logic [2:0] ERR_ALIGN  = 3'd2;
    localparam logic [2:0] ERR_SIZE   = 3'd3;
    localparam logic [2:0] ERR_PERM   = 3'd4;

    localparam int unsigned CFG_W     = 32'd8;
    localparam int unsigned CFG_R_BIT = 32'd0;
    localparam int unsigned CFG_W_BIT = 32'd1;
    localparam int unsigned CFG_A_LO  = 32'd3;
    localparam int unsigned CFG_A_HI  = 32'd4;
    localparam int unsigned CFG_L_BIT = 32'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } wr_state_e;

    function automatic logic [7:0] pack_cfg(input logic lock, input logic [1:0] mode,
                                            input logic [2:0] perm);
        return {lock, 2'b00, mode, perm};
    endfunction

endpackage

// File: rtl/pmp_napot_encode.sv
// Turns a region request (base/top, size, mode) into a pmpaddr value and flags
// requests whose size or alignment the chosen mode cannot represent.
module pmp_napot_encode
    import pmp_writer_pkg::*;
#(
    parameter int unsigned PLEN    = 56,
    parameter int unsigned PMP_LEN = 54
) (
    input  logic [PLEN-1:0]    addr,
    input  logic [5:0]         size_log2,
    input  logic [1:0]         mode,
    output logic [PMP_LEN-1:0] enc_addr,
    output logic               size_err,
    output logic               align_err
);

    localparam logic [6:0] PLEN_W = 7'(PLEN);

    logic [PMP_LEN-1:0] word_addr_s;
    logic [PLEN-1:0]    align_mask_s;
    logic [PMP_LEN-1:0] napot_mask_s;
    logic [6:0]         size_w_s;

    assign word_addr_s  = addr[PLEN-1:2];
    assign size_w_s     = {1'b0, size_log2};
    assign align_mask_s = (PLEN'(1'b1) << size_log2) - PLEN'(1'b1);
    assign napot_mask_s = (PMP_LEN'(1'b1) << (size_log2 - 6'd3)) - PMP_LEN'(1'b1);

    // Per-mode encoding and legality flags
    always_comb begin
        enc_addr  = word_addr_s;
        size_err  = 1'b0;
        align_err = 1'b0;
        case (mode)
            MODE_NAPOT: begin
                size_err  = (size_w_s < 7'd3) || (size_w_s > PLEN_W);
                align_err = |(addr & align_mask_s);
                // A whole-space region has no spare zero bit in pmpaddr, so it is all ones
                if (size_w_s == PLEN_W) begin
                    enc_addr = {PMP_LEN{1'b1}};
                end else begin
                    enc_addr = word_addr_s | napot_mask_s;
                end
            end
            MODE_NA4: begin
                size_err  = (size_log2 != 6'd2);
                align_err = |addr[1:0];
            end
            MODE_TOR: begin
                align_err = |addr[1:0];
            end
            MODE_OFF: begin
                enc_addr = word_addr_s;
            end
            default: begin
                enc_addr = word_addr_s;
            end
        endcase
    end

endmodule

// File: rtl/pmp_cfg_writer.sv
// Programs the per-entry pmpaddr/pmpcfg registers from handshaked region requests,
// enforcing lock rules, and exposes the packed state to the entry matchers.
module pmp_cfg_writer
    import pmp_writer_pkg::*;
#(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16,
    localparam int unsigned IDX_W     = $clog2(NR_ENTRIES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [IDX_W-1:0]              req_idx_i,
    input  logic [1:0]                    req_mode_i,
    input  logic [PLEN-1:0]               req_addr_i,
    input  logic [5:0]                    req_size_log2_i,
    input  logic [2:0]                    req_perm_i,
    input  logic                          req_lock_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [2:0]                    rsp_err_o,
    output logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_o,
    output logic [NR_ENTRIES*CFG_W-1:0]   conf_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 32'd1);

    wr_state_e state_r, next_state_s;
    logic ready_r, ready_nxt_s;
    logic rsp_valid_r, rsp_valid_nxt_s;
    logic [2:0] rsp_err_r;
    logic accept_s, write_en_s;

    logic [IDX_W-1:0] idx_r;
    logic [1:0]       mode_r;
    logic [PLEN-1:0]  addr_r;
    logic [5:0]       size_r;
    logic [2:0]       perm_r;
    logic             lock_r;

    logic [PMP_LEN-1:0] enc_addr_s, enc_addr_r;
    logic [2:0]         err_s, err_r;
    logic               size_err_s, align_err_s, locked_s;
    logic [IDX_W-1:0]   idx_up_s;
    logic [1:0]         up_mode_s;

    logic [PMP_LEN-1:0] addr_q_r [NR_ENTRIES];
    logic [CFG_W-1:0]   cfg_q_r  [NR_ENTRIES];

    pmp_napot_encode #(
        .PLEN    (PLEN),
        .PMP_LEN (PMP_LEN)
    ) u_encode (
        .addr      (addr_r),
        .size_log2 (size_r),
        .mode      (mode_r),
        .enc_addr  (enc_addr_s),
        .size_err  (size_err_s),
        .align_err (align_err_s)
    );

    // Lock evaluation and prioritised error code for the captured request
    always_comb begin
        idx_up_s  = idx_r + IDX_W'(1'b1);
        up_mode_s = cfg_q_r[idx_up_s][CFG_A_HI:CFG_A_LO];
        if (cfg_q_r[idx_r][CFG_L_BIT]) begin
            locked_s = 1'b1;
        end else if ((idx_r < LAST_IDX) && cfg_q_r[idx_up_s][CFG_L_BIT] &&
                     (up_mode_s == MODE_TOR)) begin
            // A locked TOR entry also freezes the entry holding its bottom bound
            locked_s = 1'b1;
        end else begin
            locked_s = 1'b0;
        end

        if (locked_s) begin
            err_s = ERR_LOCKED;
        end else if (perm_r[CFG_W_BIT] && !perm_r[CFG_R_BIT]) begin
            err_s = ERR_PERM;
        end else if (size_err_s) begin
            err_s = ERR_SIZE;
        end else if (align_err_s) begin
            err_s = ERR_ALIGN;
        end else begin
            err_s = ERR_OK;
        end
    end

    // Next-state and next-output logic of the request sequencer
    always_comb begin
        next_state_s    = state_r;
        ready_nxt_s     = 1'b0;
        rsp_valid_nxt_s = 1'b0;
        accept_s        = 1'b0;
        write_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i && ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_CHECK;
                end else begin
                    ready_nxt_s  = 1'b1;
                end
            end
            ST_CHECK: begin
                next_state_s = ST_WRITE;
            end
            ST_WRITE: begin
                write_en_s      = (err_r == ERR_OK);
                rsp_valid_nxt_s = 1'b1;
                next_state_s    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i && rsp_valid_r) begin
                    ready_nxt_s  = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    rsp_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                ready_nxt_s  = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and handshake output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            ready_r     <= ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
        end
    end

    // Request capture, encode/check results and response code
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_r      <= '0;
            mode_r     <= MODE_OFF;
            addr_r     <= '0;
            size_r     <= 6'd0;
            perm_r     <= 3'd0;
            lock_r     <= 1'b0;
            enc_addr_r <= '0;
            err_r      <= ERR_OK;
            rsp_err_r  <= ERR_OK;
        end else begin
            if (accept_s) begin
                idx_r  <= req_idx_i;
                mode_r <= req_mode_i;
                addr_r <= req_addr_i;
                size_r <= req_size_log2_i;
                perm_r <= req_perm_i;
                lock_r <= req_lock_i;
            end
            if (state_r == ST_CHECK) begin
                enc_addr_r <= enc_addr_s;
                err_r      <= err_s;
            end
            if (state_r == ST_WRITE) begin
                rsp_err_r <= err_r;
            end
        end
    end

    // PMP entry register file; lock bits persist until reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                addr_q_r[i] <= '0;
                cfg_q_r[i]  <= '0;
            end
        end else if (write_en_s) begin
            addr_q_r[idx_r] <= enc_addr_r;
            cfg_q_r[idx_r]  <= pack_cfg(lock_r, mode_r, perm_r);
        end
    end

    for (genvar g = 0; g < int'(NR_ENTRIES); g++) begin : g_pack
        assign conf_addr_o[g*PMP_LEN +: PMP_LEN] = addr_q_r[g];
        assign conf_o[g*CFG_W +: CFG_W]          = cfg_q_r[g];
    end

    assign req_ready_o = ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_pmp_cfg_writer.sv
// Directed self-checking bench for pmp_cfg_writer: encoding, error priority, locks,
// handshake timing, reset behaviour and a matcher round trip of written regions.
module tb_pmp_cfg_writer;

    localparam int unsigned PLEN    = 56;
    localparam int unsigned PMP_LEN = 54;
    localparam int unsigned NR      = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid, req_ready;
    logic [3:0]              req_idx;
    logic [1:0]              req_mode;
    logic [PLEN-1:0]         req_addr;
    logic [5:0]              req_size;
    logic [2:0]              req_perm;
    logic                    req_lock;
    logic                    rsp_valid, rsp_ready;
    logic [2:0]              rsp_err;
    logic [NR*PMP_LEN-1:0]   conf_addr;
    logic [NR*8-1:0]         conf;

    int vectors = 0;
    int miscompares = 0;

    pmp_cfg_writer #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_idx_i       (req_idx),
        .req_mode_i      (req_mode),
        .req_addr_i      (req_addr),
        .req_size_log2_i (req_size),
        .req_perm_i      (req_perm),
        .req_lock_i      (req_lock),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_err_o       (rsp_err),
        .conf_addr_o     (conf_addr),
        .conf_o          (conf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PMP_LEN-1:0] ent_addr(input int i);
        return conf_addr[i*PMP_LEN +: PMP_LEN];
    endfunction

    function automatic logic [7:0] ent_cfg(input int i);
        return conf[i*8 +: 8];
    endfunction

    task automatic check_entry(input int i, input logic [63:0] ea, input logic [7:0] ec);
        check($sformatf("addr[%0d]", i), 64'(ent_addr(i)), ea);
        check($sformatf("cfg[%0d]", i), 64'(ent_cfg(i)), 64'(ec));
    endtask

    // Independent PMP matcher: TOR uses the previous entry as bottom bound
    function automatic logic pmp_match(input logic [PLEN-1:0] a, input int i);
        logic [PMP_LEN-1:0] pa, prev;
        logic [PLEN:0] x, m;
        pa   = ent_addr(i);
        prev = (i > 0) ? ent_addr(i - 1) : '0;
        case (ent_cfg(i)[4:3])
            2'b01:   return (a[PLEN-1:2] >= prev) && (a[PLEN-1:2] < pa);
            2'b10:   return a[PLEN-1:2] == pa;
            2'b11: begin
                x = {1'b0, pa, 2'b11};
                m = x ^ (x + 57'd1);
                return ((({1'b0, a}) ^ x) & ~m) == 57'd0;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic round_trip(input int i, input logic [PLEN-1:0] lo, input logic [PLEN-1:0] hi);
        check($sformatf("rt%0d lo", i), 64'(pmp_match(lo, i)), 64'd1);
        check($sformatf("rt%0d hi", i), 64'(pmp_match(hi, i)), 64'd1);
        check($sformatf("rt%0d below", i), 64'(pmp_match(lo - 56'd1, i)), 64'd0);
        check($sformatf("rt%0d above", i), 64'(pmp_match(hi + 56'd1, i)), 64'd0);
    endtask

    // One full transaction from IDLE; entered and left at #1 after a clock edge
    task automatic do_req(input string tag, input int idx, input logic [1:0] mode,
                          input logic [PLEN-1:0] addr, input logic [5:0] sz,
                          input logic [2:0] perm, input logic lk,
                          input logic [2:0] exp_err, input int hold);
        check({tag, " ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_idx   = 4'(idx);
        req_mode  = mode;
        req_addr  = addr;
        req_size  = sz;
        req_perm  = perm;
        req_lock  = lk;
        @(posedge clk); #1;
        // Scramble inputs so only the captured copy can produce the result
        req_valid = 1'b0;
        req_idx   = ~req_idx;
        req_addr  = ~req_addr;
        req_mode  = ~req_mode;
        req_perm  = 3'b010;
        check({tag, " busy"}, 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check({tag, " early"}, 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, " valid"}, 64'(rsp_valid), 64'd1);
        check({tag, " err"}, 64'(rsp_err), 64'(exp_err));
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1;
            req_idx   = 4'd9;
            req_mode  = 2'b10;
            req_addr  = 56'h0;
            req_size  = 6'd2;
            req_perm  = 3'b001;
            @(posedge clk); #1;
            check({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
            check({tag, " hold err"}, 64'(rsp_err), 64'(exp_err));
            check({tag, " hold ready"}, 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " done"}, 64'(rsp_valid), 64'd0);
        check({tag, " reready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_idx = 4'd0; req_mode = 2'b00; req_addr = '0; req_size = 6'd0;
        req_perm = 3'd0; req_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset addr", 64'(|conf_addr), 64'd0);
        check("reset cfg", 64'(|conf), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset ready", 64'(req_ready), 64'd1);

        // Basic encodings
        do_req("napot0", 0, 2'b11, 56'h8000_0000, 6'd12, 3'b111, 1'b0, 3'd0, 0);
        check_entry(0, 64'h2000_01FF, 8'h1F);
        do_req("na4_1", 1, 2'b10, 56'h1000, 6'd2, 3'b001, 1'b0, 3'd0, 0);
        check_entry(1, 64'h400, 8'h11);
        do_req("tor2", 2, 2'b01, 56'h9000_0000, 6'd0, 3'b011, 1'b0, 3'd0, 5);
        check_entry(2, 64'h2400_0000, 8'h0B);
        check_entry(9, 64'h0, 8'h00);

        // Error codes and priorities, entry 3 must stay clear throughout
        do_req("align", 3, 2'b11, 56'h8000_0800, 6'd12, 3'b111, 1'b0, 3'd2, 0);
        do_req("perm", 3, 2'b11, 56'h8000_0000, 6'd12, 3'b010, 1'b0, 3'd4, 0);
        do_req("napot small", 3, 2'b11, 56'h0, 6'd2, 3'b001, 1'b0, 3'd3, 0);
        do_req("na4 size", 3, 2'b10, 56'h1000, 6'd3, 3'b001, 1'b0, 3'd3, 0);
        do_req("napot big", 3, 2'b11, 56'h0, 6'd57, 3'b001, 1'b0, 3'd3, 0);
        do_req("tor align", 3, 2'b01, 56'h1002, 6'd0, 3'b001, 1'b0, 3'd2, 0);
        do_req("perm>size", 3, 2'b11, 56'h0, 6'd2, 3'b010, 1'b0, 3'd4, 0);
        do_req("size>align", 3, 2'b10, 56'h1001, 6'd3, 3'b001, 1'b0, 3'd3, 0);
        check_entry(3, 64'h0, 8'h00);
        check_entry(0, 64'h2000_01FF, 8'h1F);

        // Boundary sizes, last entry, OFF mode
        do_req("whole", 7, 2'b11, 56'h0, 6'd56, 3'b001, 1'b0, 3'd0, 0);
        check_entry(7, 64'h3F_FFFF_FFFF_FFFF, 8'h19);
        do_req("whole align", 7, 2'b11, 56'h10, 6'd56, 3'b111, 1'b0, 3'd2, 0);
        check_entry(7, 64'h3F_FFFF_FFFF_FFFF, 8'h19);
        do_req("last8", 15, 2'b11, 56'h8, 6'd3, 3'b111, 1'b0, 3'd0, 0);
        check_entry(15, 64'h2, 8'h1F);
        do_req("off", 8, 2'b00, 56'h1234, 6'd0, 3'b101, 1'b0, 3'd0, 0);
        check_entry(8, 64'h48D, 8'h05);

        // Locks
        do_req("lock4", 4, 2'b11, 56'h1_0000, 6'd16, 3'b111, 1'b1, 3'd0, 0);
        check_entry(4, 64'h5FFF, 8'h9F);
        do_req("rewrite4", 4, 2'b10, 56'h2000, 6'd2, 3'b001, 1'b0, 3'd1, 0);
        do_req("lock>perm", 4, 2'b10, 56'h2000, 6'd2, 3'b010, 1'b0, 3'd1, 0);
        check_entry(4, 64'h5FFF, 8'h9F);
        do_req("tor6 lock", 6, 2'b01, 56'h2_0000, 6'd0, 3'b001, 1'b1, 3'd0, 0);
        check_entry(6, 64'h8000, 8'h89);
        do_req("below tor", 5, 2'b10, 56'h3000, 6'd2, 3'b001, 1'b0, 3'd1, 0);
        check_entry(5, 64'h0, 8'h00);
        do_req("below napot", 3, 2'b10, 56'h4000, 6'd2, 3'b001, 1'b0, 3'd0, 0);
        check_entry(3, 64'h1000, 8'h11);

        // Matcher round trip on written regions
        round_trip(0, 56'h8000_0000, 56'h8000_0FFF);
        round_trip(1, 56'h1000, 56'h1003);
        round_trip(2, 56'h1000, 56'h8FFF_FFFF);
        round_trip(4, 56'h1_0000, 56'h1_FFFF);
        round_trip(15, 56'h8, 56'hF);

        // Reset while a request sits in CHECK
        req_valid = 1'b1; req_idx = 4'd9; req_mode = 2'b11;
        req_addr = 56'h8000_0000; req_size = 6'd12; req_perm = 3'b111; req_lock = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst addr", 64'(|conf_addr), 64'd0);
        check("midrst cfg", 64'(|conf), 64'd0);
        check("midrst rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst rsp_err", 64'(rsp_err), 64'd0);
        check("midrst ready", 64'(req_ready), 64'd1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("postrst cfg", 64'(|conf), 64'd0);
        check("postrst rsp_valid", 64'(rsp_valid), 64'd0);
        req_lock = 1'b0;
        do_req("unlock4", 4, 2'b10, 56'h2000, 6'd2, 3'b001, 1'b0, 3'd0, 0);
        check_entry(4, 64'h800, 8'h11);
        do_req("unlock5", 5, 2'b10, 56'h3000, 6'd2, 3'b001, 1'b0, 3'd0, 0);
        check_entry(5, 64'hC00, 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
